// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings,
// FSM state type and op-legality helpers.
package alu_pkg;

    // ALU operation encodings as seen by the processor and the 1-bit slice
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b101;

    // Sequencer FSM state
    typedef logic [1:0] bsa_state_t;
    localparam bsa_state_t ST_IDLE = 2'd0;
    localparam bsa_state_t ST_RUN  = 2'd1;
    localparam bsa_state_t ST_DONE = 2'd2;

    // Encodings 011 and 100 have no meaning for the slice
    function automatic logic is_legal_op(input logic [2:0] op);
        return !((op == 3'b011) || (op == 3'b100));
    endfunction

    // Pure bitwise ops (no carry chain involved)
    function automatic logic is_logic_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first,
// one bit per clock, and assembles the WIDTH-bit result with flags.
// Optional build macro BSA_FAST_LOGIC_EN: AND/OR/NOR are computed
// word-parallel at acceptance and skip the serial pass.
module bit_serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal_op,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_ci,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_r,
    input  logic             slice_co
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    bsa_state_t       state_reg;
    logic [WIDTH-1:0] a_reg, b_reg, sr_reg, result_reg;
    logic [2:0]       op_reg;
    logic [KW-1:0]    k_reg;
    logic             carry_reg, zero_reg, carry_out_reg, overflow_reg, illegal_reg;

    logic             sub_like;
    logic             ovf_next;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] result_next;
    logic             carry_out_next, overflow_next;

`ifdef BSA_FAST_LOGIC_EN
    function automatic logic [WIDTH-1:0] word_logic(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic [2:0]       op);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            default: return ~(x | y);
        endcase
    endfunction
`endif

    assign sub_like = (op_reg == OP_SUB) || (op_reg == OP_SLT);
    assign ready    = (state_reg == ST_IDLE);
    assign done     = (state_reg == ST_DONE);

    assign result     = result_reg;
    assign zero       = zero_reg;
    assign carry_out  = carry_out_reg;
    assign overflow   = overflow_reg;
    assign illegal_op = illegal_reg;

    // Slice drive: active only in RUN; SLT runs the slice as a subtract
    always_comb begin
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_ci   = 1'b0;
        slice_less = 1'b0;
        slice_op   = 3'b000;
        if (state_reg == ST_RUN) begin
            slice_a  = a_reg[k_reg];
            slice_b  = b_reg[k_reg];
            slice_op = (op_reg == OP_SLT) ? OP_SUB : op_reg;
            slice_ci = (k_reg == '0) ? sub_like : carry_reg;
        end
    end

    // Final-bit result assembly, used on the last RUN edge
    always_comb begin
        sr_next        = {slice_r, sr_reg[WIDTH-1:1]};
        ovf_next       = slice_ci ^ slice_co;
        result_next    = sr_next;
        carry_out_next = 1'b0;
        overflow_next  = 1'b0;
        if (op_reg == OP_SLT) begin
            // sign of (a-b) corrected by overflow gives signed less-than
            result_next = {{(WIDTH-1){1'b0}}, slice_r ^ ovf_next};
        end else if ((op_reg == OP_ADD) || (op_reg == OP_SUB)) begin
            carry_out_next = slice_co;
            overflow_next  = ovf_next;
        end
    end

    // Sequencer state, operand capture, serial shift and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= 3'b000;
            k_reg         <= '0;
            carry_reg     <= 1'b0;
            sr_reg        <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        op_reg    <= alu_op;
                        k_reg     <= '0;
                        carry_reg <= 1'b0;
                        if (!is_legal_op(alu_op)) begin
                            result_reg    <= '0;
                            zero_reg      <= 1'b1;
                            carry_out_reg <= 1'b0;
                            overflow_reg  <= 1'b0;
                            illegal_reg   <= 1'b1;
                            state_reg     <= ST_DONE;
`ifdef BSA_FAST_LOGIC_EN
                        end else if (is_logic_op(alu_op)) begin
                            result_reg    <= word_logic(a, b, alu_op);
                            zero_reg      <= (word_logic(a, b, alu_op) == '0);
                            carry_out_reg <= 1'b0;
                            overflow_reg  <= 1'b0;
                            illegal_reg   <= 1'b0;
                            state_reg     <= ST_DONE;
`endif
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    sr_reg    <= sr_next;
                    carry_reg <= slice_co;
                    k_reg     <= k_reg + 1'b1;
                    if (k_reg == K_LAST) begin
                        result_reg    <= result_next;
                        zero_reg      <= (result_next == '0);
                        carry_out_reg <= carry_out_next;
                        overflow_reg  <= overflow_next;
                        illegal_reg   <= 1'b0;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Scoreboard bench for bit_serial_alu_seq with a behavioural 1-bit slice.
module tb_bit_serial_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   alu_op = 3'b000;
    logic         ready, done, zero, carry_out, overflow, illegal_op;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_ci, slice_less, slice_r, slice_co;
    logic [2:0]   slice_op;
    logic         slice_bb;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         ill;
        int           lat;
        int           acc;
        logic [2:0]   op;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   applied = 0;
    int   checks = 0;
    int   miscompares = 0;
    int   idle_fail_prints = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_op(alu_op),
        .ready(ready), .done(done), .result(result), .zero(zero),
        .carry_out(carry_out), .overflow(overflow), .illegal_op(illegal_op),
        .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci),
        .slice_less(slice_less), .slice_op(slice_op),
        .slice_r(slice_r), .slice_co(slice_co)
    );

    // Behavioural 1-bit ALU slice (aluOp[2] inverts B)
    always_comb begin
        slice_bb = slice_op[2] ? ~slice_b : slice_b;
        slice_co = (slice_a & slice_bb) | (slice_a & slice_ci) | (slice_bb & slice_ci);
        case (slice_op)
            3'b000:  slice_r = slice_a & slice_b;
            3'b001:  slice_r = slice_a | slice_b;
            3'b010,
            3'b110:  slice_r = slice_a ^ slice_bb ^ slice_ci;
            3'b111:  slice_r = slice_less;
            3'b101:  slice_r = ~(slice_a | slice_b);
            default: slice_r = 1'b0;
        endcase
    end

    // Reference: word-level arithmetic of the requested operation
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] op);
        exp_t     e;
        logic [W:0] s;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = W; e.acc = 0; e.op = op;
        case (op)
            3'b000: begin
                e.res = x & y;
`ifdef BSA_FAST_LOGIC_EN
                e.lat = 0;
`endif
            end
            3'b001: begin
                e.res = x | y;
`ifdef BSA_FAST_LOGIC_EN
                e.lat = 0;
`endif
            end
            3'b101: begin
                e.res = ~(x | y);
`ifdef BSA_FAST_LOGIC_EN
                e.lat = 0;
`endif
            end
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'b110: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'b111: begin
                e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            end
            default: begin
                e.res = '0;
                e.ill = 1'b1;
                e.lat = 0;
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", W'(done), W'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("zero", W'(zero), W'(e.z));
                    chk("carry_out", W'(carry_out), W'(e.c));
                    chk("overflow", W'(overflow), W'(e.v));
                    chk("illegal_op", W'(illegal_op), W'(e.ill));
                    chk("latency", W'(cyc - e.acc), W'(e.lat));
                    chk("ready_in_done", W'(ready), W'(0));
                    $display("op=%b result=%h z=%b c=%b v=%b ill=%b lat=%0d",
                             e.op, result, zero, carry_out, overflow, illegal_op, cyc - e.acc);
                end
            end
            if ((ready || done) &&
                ({slice_a, slice_b, slice_ci, slice_less, slice_op} != 7'd0)) begin
                miscompares++;
                if (idle_fail_prints < 10) begin
                    idle_fail_prints++;
                    $display("FAIL slice_idle: got %b expected 0000000 (cycle %0d)",
                             {slice_a, slice_b, slice_ci, slice_less, slice_op}, cyc);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        exp_t e;
        int   n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", W'(ready), W'(1));
            return;
        end
        a = x; b = y; alu_op = op; start = 1'b1;
        e = model(x, y, op);
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb_q.push_back(e);
        applied++;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        alu_op = 3'($urandom_range(0, 7));
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", W'(sb_q.size()), W'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, W'(ready), W'(1));
        chk({tag, "_done"}, W'(done), W'(0));
        chk({tag, "_result"}, result, W'(0));
        chk({tag, "_zero"}, W'(zero), W'(1));
        chk({tag, "_carry"}, W'(carry_out), W'(0));
        chk({tag, "_ovf"}, W'(overflow), W'(0));
        chk({tag, "_illegal"}, W'(illegal_op), W'(0));
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic [2:0]   op;
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(32'd5, 32'd3, 3'b010);
        issue(32'd3, 32'd5, 3'b110);
        issue(32'd7, 32'd7, 3'b110);
        issue(32'h8000_0000, 32'd1, 3'b111);
        issue(32'd1, 32'h8000_0000, 3'b111);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        issue(32'h7FFF_FFFF, 32'd1, 3'b010);
        issue(32'd0, 32'd0, 3'b101);
        issue(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000);
        issue(32'hF0F0_1234, 32'h0FF0_0000, 3'b001);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 3'b011);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 3'b100);
        issue(32'hFFFF_FFFF, 32'd1, 3'b010);
        issue(32'h8000_0000, 32'd1, 3'b110);
        drain();

        // start pulsed mid-RUN must be ignored
        issue(32'd100, 32'd23, 3'b010);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("busy_ready", W'(ready), W'(0));
        start = 1'b1; alu_op = 3'b011; a = 32'hDEAD_BEEF; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset in the middle of a serial operation aborts it
        issue(32'd1, 32'd2, 3'b010);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk_reset_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin x = 32'h8000_0000; y = $urandom; end
                1: begin x = $urandom; y = 32'h7FFF_FFFF; end
                2: begin x = $urandom; y = x; end
                default: begin x = $urandom; y = $urandom; end
            endcase
            issue(x, y, op);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
